// File: rtl/fd_stim_pkg.sv
// fd_stim_pkg
//   Shared types and the flop reference model for the fd_stim_seq sequencer.
//   - state_t : sequencer FSM states
//   - vec_t   : one stimulus vector {d, clr_n, set_n}, same bit order as wr_data
//   - ref_q() : 2-state expected q of the clear/set D flop after a clock edge
package fd_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EDGE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    typedef struct packed {
        logic d;
        logic clr_n;
        logic set_n;
    } vec_t;

    // Set wins over clear when both are asserted.
    function automatic logic ref_q(input vec_t v);
        if (!v.set_n) begin
            return 1'b1;
        end else if (!v.clr_n) begin
            return 1'b0;
        end
        return v.d;
    endfunction

endpackage

// File: rtl/fd_stim_seq_ref_model.sv
// fd_stim_ref_model
//   Combinational reference model of the clear/set D flop: the q value the
//   flop must show after a rising clock edge with the given pins applied.
// Ports
//   vec_i   in  3  {d, clr_n, set_n} currently on the flop pins
//   exp_q_o out 1  expected q
module fd_stim_ref_model
    import fd_stim_pkg::*;
(
    input  logic [2:0] vec_i,
    output logic       exp_q_o
);

    assign exp_q_o = ref_q(vec_t'(vec_i));

endmodule

// File: rtl/fd_stim_seq.sv
// fd_stim_seq
//   Vector-driven stimulus sequencer and checker for a clear/set D flop.
//   Replays a loaded table of {d, clr_n, set_n} vectors onto the flop pins,
//   generates the flop clock, samples the returned q after a settle window,
//   compares it against the reference model and counts mismatches.
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    vector table write (dropped while busy)
//   vec_count                vectors to run, sampled on start (0..DEPTH)
//   start                    launch pulse, honoured in IDLE or DONE only
//   dut_q                    q returned by the flop
//   loop                     (FD_STIM_LOOP_EN only) wrap to vector 0 after the last
//   fclk, fd_d, fd_clr_n, fd_set_n  registered flop clock and pins
//   busy, done               run status; done holds until next start or rst
//   err_cnt                  saturating mismatch count
//   first_err_idx            index of first mismatching vector
// Configuration
//   FD_STIM_LOOP_EN          adds the loop input; undefined = single pass
module fd_stim_seq
    import fd_stim_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 12,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic [AW:0]   vec_count,
    input  logic          start,
    input  logic          dut_q,
`ifdef FD_STIM_LOOP_EN
    input  logic          loop,
`endif
    output logic          fclk,
    output logic          fd_d,
    output logic          fd_clr_n,
    output logic          fd_set_n,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] first_err_idx
);

    localparam int CTRW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CTRW-1:0] ctr_q, ctr_d;
    vec_t          vec_q, vec_d;
    logic          fclk_q, fclk_d;
    logic          refq_q, refq_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] err_q, err_d;
    logic [AW-1:0] first_q, first_d;

    vec_t          table_q [DEPTH];

    logic          ref_w;
    logic          last_w;
    logic          miss_w;
    logic          loop_w;

`ifdef FD_STIM_LOOP_EN
    assign loop_w = loop;
`else
    assign loop_w = 1'b0;
`endif

    // Reference model looks at the pins already driven, so exp matches
    // exactly what the flop sees at the fclk rising edge.
    fd_stim_ref_model u_ref (
        .vec_i   (vec_q),
        .exp_q_o (ref_w)
    );

    assign last_w = ({1'b0, ptr_q} == (cnt_q - (AW+1)'(1)));
    // 4-state compare so an X/Z from the flop counts as a mismatch.
    assign miss_w = (dut_q !== refq_q);

    // Table survives rst; writes are only accepted while no run is active,
    // so the vector in flight can never be overwritten.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            table_q[wr_addr] <= vec_t'(wr_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ctr_q   <= '0;
            vec_q   <= vec_t'(3'b011);
            fclk_q  <= 1'b0;
            refq_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            vec_q   <= vec_d;
            fclk_q  <= fclk_d;
            refq_q  <= refq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ctr_d   = ctr_q;
        vec_d   = vec_q;
        fclk_d  = fclk_q;
        refq_d  = refq_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        first_d = first_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                fclk_d = 1'b0;
                if (start) begin
                    err_d   = '0;
                    first_d = '0;
                    ptr_d   = '0;
                    cnt_d   = vec_count;
                    if (vec_count == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                vec_d   = table_q[ptr_q];
                fclk_d  = 1'b0;
                state_d = S_EDGE;
            end
            S_EDGE: begin
                fclk_d  = 1'b1;
                refq_d  = ref_w;
                ctr_d   = CTRW'(SETTLE - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (ctr_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    ctr_d = ctr_q - CTRW'(1);
                end
            end
            S_CHECK: begin
                if (miss_w) begin
                    if (err_q != '1) begin
                        err_d = err_q + CW'(1);
                    end
                    if (err_q == '0) begin
                        first_d = ptr_q;
                    end
                end
                // Drop fclk here so the next vector sees a clean low phase.
                fclk_d = 1'b0;
                if (!last_w) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = S_SETUP;
                end else if (loop_w) begin
                    ptr_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fclk          = fclk_q;
    assign fd_d          = vec_q.d;
    assign fd_clr_n      = vec_q.clr_n;
    assign fd_set_n      = vec_q.set_n;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_cnt       = err_q;
    assign first_err_idx = first_q;

endmodule
